// File: rtl/word_gen_range_loader.sv
// -----------------------------------------------------------------------------
// word_gen_range_loader
//
// Purpose:
//   Parses a word-generator range configuration byte stream coming from the
//   packet input FIFO and drives the configuration write ports of the
//   word_gen_char_range array (whose CONF_CLK is OP_CLK).
//   Stream layout: NR, then NR records {NC, NC chars, SI}, then 8'hBB.
//
// Ports:
//   OP_CLK             clock, rising edge
//   rstb               synchronous reset, active-high
//   din/din_valid      input byte stream; din_ready is the handshake back
//   conf_din           registered byte payload (CHAR_BITS wide)
//   conf_range         index of the range being configured
//   conf_en_num_chars  write strobe for num_chars flags (num_chars_eq0/lt2)
//   conf_en_chars      write strobe for a char table entry at conf_char_addr,
//                      pre_end_char marks the second-to-last entry
//   conf_en_start_idx  write strobe for start_idx (= conf_din)
//   done               one-cycle pulse after a complete, valid configuration
//   err/err_code       sticky error: 1 NR, 2 NC, 3 char, 4 SI, 5 terminator
// -----------------------------------------------------------------------------
module word_gen_range_loader #(
  parameter int CHAR_BITS        = 7,
  parameter int RANGES_MAX       = 8,
  parameter int CHARS_NUMBER_MAX = (CHAR_BITS == 7) ? 96 : 224,
  parameter int RANGE_MSB        = ($clog2(RANGES_MAX) > 0) ? $clog2(RANGES_MAX) - 1 : 0,
  parameter int NUM_CHARS_MSB    = $clog2(CHARS_NUMBER_MAX + 1) - 1
) (
  input  logic                   OP_CLK,
  input  logic                   rstb,
  input  logic [7:0]             din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [CHAR_BITS-1:0]   conf_din,
  output logic [RANGE_MSB:0]     conf_range,
  output logic                   conf_en_num_chars,
  output logic                   num_chars_eq0,
  output logic                   num_chars_lt2,
  output logic                   conf_en_chars,
  output logic [NUM_CHARS_MSB:0] conf_char_addr,
  output logic                   pre_end_char,
  output logic                   conf_en_start_idx,
  output logic                   done,
  output logic                   err,
  output logic [2:0]             err_code
);

  localparam int RW = RANGE_MSB + 1;
  localparam int NW = NUM_CHARS_MSB + 1;

  localparam logic [7:0]  TERM_BYTE = 8'hBB;
  localparam logic [NW-1:0] ONE_A   = NW'(1);
  localparam logic [NW:0]   ONE_N   = (NW + 1)'(1);
  localparam logic [NW:0]   TWO_N   = (NW + 1)'(2);
  localparam logic [RW-1:0] ONE_R   = RW'(1);
  localparam logic [RW:0]   ONE_RX  = (RW + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_NUM_CHARS, S_CHARS, S_START_IDX, S_TERM, S_DONE, S_ERROR
  } state_t;

  state_t          state_q;
  logic [RW:0]     nr_q;          // one bit wider than the range index: NR may equal RANGES_MAX
  logic [RW-1:0]   range_cnt_q;
  logic [NW-1:0]   nc_q;
  logic [NW-1:0]   addr_cnt_q;

  logic [CHAR_BITS-1:0] conf_din_q;
  logic [RW-1:0]   conf_range_q;
  logic            en_num_chars_q, eq0_q, lt2_q;
  logic            en_chars_q, pre_end_q;
  logic [NW-1:0]   conf_char_addr_q;
  logic            en_start_idx_q, done_q, err_q;
  logic [2:0]      err_code_q;

  logic            accept;
  logic [7:0]      nc_byte;
  logic            nr_bad, nc_bad, char_bad, si_bad;
  logic            last_char, pre_end_hit, last_range;

  assign din_ready = (state_q == S_IDLE) || (state_q == S_NUM_CHARS) ||
                     (state_q == S_CHARS) || (state_q == S_START_IDX) ||
                     (state_q == S_TERM);
  assign accept    = din_valid && din_ready;

  assign nc_byte   = 8'(nc_q);
  assign nr_bad    = (din == 8'd0) || (din > 8'(RANGES_MAX));
  assign nc_bad    = din > 8'(CHARS_NUMBER_MAX);
  assign char_bad  = (CHAR_BITS == 7) && din[7];
  // With NC==0 the only legal start index is 0.
  assign si_bad    = (nc_q == '0) ? (din != 8'd0) : (din >= nc_byte);

  // Compare in a widened domain so NC-1 / NC-2 never underflow.
  assign last_char   = ({1'b0, addr_cnt_q} + ONE_N) == {1'b0, nc_q};
  assign pre_end_hit = ({1'b0, addr_cnt_q} + TWO_N) == {1'b0, nc_q};
  assign last_range  = ({1'b0, range_cnt_q} + ONE_RX) == nr_q;

  always_ff @(posedge OP_CLK) begin
    if (rstb) begin
      state_q          <= S_IDLE;
      nr_q             <= '0;
      range_cnt_q      <= '0;
      nc_q             <= '0;
      addr_cnt_q       <= '0;
      conf_din_q       <= '0;
      conf_range_q     <= '0;
      en_num_chars_q   <= 1'b0;
      eq0_q            <= 1'b0;
      lt2_q            <= 1'b0;
      en_chars_q       <= 1'b0;
      pre_end_q        <= 1'b0;
      conf_char_addr_q <= '0;
      en_start_idx_q   <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      err_code_q       <= 3'd0;
    end else begin
      // Strobes are single-cycle by default.
      en_num_chars_q <= 1'b0;
      en_chars_q     <= 1'b0;
      en_start_idx_q <= 1'b0;
      pre_end_q      <= 1'b0;
      done_q         <= 1'b0;

      if (accept) begin
        conf_din_q <= din[CHAR_BITS-1:0];
      end

      case (state_q)
        S_IDLE: if (accept) begin
          if (nr_bad) begin
            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 3'd1;
          end else begin
            nr_q        <= din[RW:0];
            range_cnt_q <= '0;
            state_q     <= S_NUM_CHARS;
          end
        end
        S_NUM_CHARS: if (accept) begin
          if (nc_bad) begin
            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 3'd2;
          end else begin
            nc_q             <= din[NW-1:0];
            en_num_chars_q   <= 1'b1;
            eq0_q            <= (din == 8'd0);
            lt2_q            <= (din < 8'd2);
            addr_cnt_q       <= '0;
            conf_char_addr_q <= '0;
            conf_range_q     <= range_cnt_q;
            state_q          <= (din == 8'd0) ? S_START_IDX : S_CHARS;
          end
        end
        S_CHARS: if (accept) begin
          if (char_bad) begin
            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 3'd3;
          end else begin
            en_chars_q       <= 1'b1;
            conf_char_addr_q <= addr_cnt_q;
            conf_range_q     <= range_cnt_q;
            pre_end_q        <= pre_end_hit;
            if (last_char) state_q <= S_START_IDX;
            else           addr_cnt_q <= addr_cnt_q + ONE_A;
          end
        end
        S_START_IDX: if (accept) begin
          if (si_bad) begin
            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 3'd4;
          end else begin
            en_start_idx_q <= 1'b1;
            conf_range_q   <= range_cnt_q;
            if (last_range) begin
              state_q <= S_TERM;
            end else begin
              range_cnt_q <= range_cnt_q + ONE_R;
              state_q     <= S_NUM_CHARS;
            end
          end
        end
        S_TERM: if (accept) begin
          if (din == TERM_BYTE) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_ERROR; err_q <= 1'b1; err_code_q <= 3'd5;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        S_ERROR: state_q <= S_ERROR;   // only rstb leaves the error state
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign conf_din          = conf_din_q;
  assign conf_range        = conf_range_q;
  assign conf_en_num_chars = en_num_chars_q;
  assign num_chars_eq0     = eq0_q;
  assign num_chars_lt2     = lt2_q;
  assign conf_en_chars     = en_chars_q;
  assign conf_char_addr    = conf_char_addr_q;
  assign pre_end_char      = pre_end_q;
  assign conf_en_start_idx = en_start_idx_q;
  assign done              = done_q;
  assign err               = err_q;
  assign err_code          = err_code_q;

endmodule

// File: tb/tb_word_gen_range_loader.sv
// -----------------------------------------------------------------------------
// tb_word_gen_range_loader
//
// Purpose:
//   Drives configuration byte streams into word_gen_range_loader. Each byte
//   that must cause a write strobe (or the done pulse) pushes the expected
//   event into a queue; a monitor pops and compares on every observed strobe.
// -----------------------------------------------------------------------------
module tb_word_gen_range_loader;

  logic       OP_CLK = 1'b0;
  logic       rstb;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [6:0] conf_din;
  logic [2:0] conf_range;
  logic       conf_en_num_chars, num_chars_eq0, num_chars_lt2;
  logic       conf_en_chars;
  logic [6:0] conf_char_addr;
  logic       pre_end_char, conf_en_start_idx, done, err;
  logic [2:0] err_code;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 OP_CLK = ~OP_CLK;

  word_gen_range_loader dut (
    .OP_CLK            (OP_CLK),
    .rstb              (rstb),
    .din               (din),
    .din_valid         (din_valid),
    .din_ready         (din_ready),
    .conf_din          (conf_din),
    .conf_range        (conf_range),
    .conf_en_num_chars (conf_en_num_chars),
    .num_chars_eq0     (num_chars_eq0),
    .num_chars_lt2     (num_chars_lt2),
    .conf_en_chars     (conf_en_chars),
    .conf_char_addr    (conf_char_addr),
    .pre_end_char      (pre_end_char),
    .conf_en_start_idx (conf_en_start_idx),
    .done              (done),
    .err               (err),
    .err_code          (err_code)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=%0h", tag, got);
    end
  endtask

  // Event word: kind 1 num_chars, 2 char, 3 start_idx, 4 done, 7 multiple strobes.
  function automatic logic [31:0] ev(input logic [2:0] k, input logic [2:0] r,
                                     input logic [6:0] a, input logic [6:0] d,
                                     input logic eq0, input logic lt2, input logic pre);
    return {9'd0, k, r, a, d, eq0, lt2, pre};
  endfunction

  int          mon_ns;
  logic [2:0]  mon_k;
  logic [31:0] mon_obs;

  always @(negedge OP_CLK) begin
    mon_ns = int'(conf_en_num_chars) + int'(conf_en_chars) +
             int'(conf_en_start_idx) + int'(done);
    if (mon_ns != 0) begin
      if (mon_ns > 1)             mon_k = 3'd7;
      else if (conf_en_num_chars) mon_k = 3'd1;
      else if (conf_en_chars)     mon_k = 3'd2;
      else if (conf_en_start_idx) mon_k = 3'd3;
      else                        mon_k = 3'd4;
      mon_obs = ev(mon_k,
                   (mon_k == 3'd4) ? 3'd0 : conf_range,
                   (mon_k == 3'd2) ? conf_char_addr : 7'd0,
                   (mon_k == 3'd4) ? 7'd0 : conf_din,
                   (mon_k == 3'd1) ? num_chars_eq0 : 1'b0,
                   (mon_k == 3'd1) ? num_chars_lt2 : 1'b0,
                   (mon_k == 3'd2) ? pre_end_char  : 1'b0);
      if (exp_q.size() == 0) check_val("unexpected_strobe", mon_obs, 32'd0);
      else                   check_val("strobe", mon_obs, exp_q.pop_front());
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input bit pe, input logic [31:0] e, input int gap);
    int n;
    n = 0;
    while (!din_ready && n < 20) begin
      @(negedge OP_CLK);
      n++;
    end
    if (!din_ready) begin
      check_val("ready_timeout", {31'd0, din_ready}, 32'd1);
      return;
    end
    if (pe) exp_q.push_back(e);
    din = b;
    din_valid = 1'b1;
    @(negedge OP_CLK);
    din_valid = 1'b0;
    repeat (gap) @(negedge OP_CLK);
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge OP_CLK);
    check_val(tag, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rstb = 1'b1;
    din_valid = 1'b0;
    repeat (2) @(negedge OP_CLK);
    rstb = 1'b0;
  endtask

  task automatic stream_t1(input int gap);
    send(8'h01, 0, 32'd0, gap);
    send(8'h03, 1, ev(3'd1, 3'd0, 7'd0, 7'h03, 1'b0, 1'b0, 1'b0), gap);
    send(8'h61, 1, ev(3'd2, 3'd0, 7'd0, 7'h61, 1'b0, 1'b0, 1'b0), gap);
    send(8'h62, 1, ev(3'd2, 3'd0, 7'd1, 7'h62, 1'b0, 1'b0, 1'b1), gap);
    send(8'h63, 1, ev(3'd2, 3'd0, 7'd2, 7'h63, 1'b0, 1'b0, 1'b0), gap);
    send(8'h01, 1, ev(3'd3, 3'd0, 7'd0, 7'h01, 1'b0, 1'b0, 1'b0), gap);
    send(8'hBB, 1, ev(3'd4, 3'd0, 7'd0, 7'd0,  1'b0, 1'b0, 1'b0), gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstb = 1'b1;
    din = 8'd0;
    din_valid = 1'b0;
    repeat (3) @(negedge OP_CLK);
    check_val("reset_ready", {31'd0, din_ready}, 32'd1);
    check_val("reset_outs", {14'd0, conf_en_num_chars, conf_en_chars, conf_en_start_idx,
                             done, err, err_code, conf_range, conf_char_addr}, 32'd0);
    rstb = 1'b0;

    // 1: single range of three chars
    stream_t1(0);
    check_val("t1_ready_in_done", {31'd0, din_ready}, 32'd0);
    @(negedge OP_CLK);
    check_val("t1_ready_after", {31'd0, din_ready}, 32'd1);
    check_val("t1_err", {28'd0, err, err_code}, 32'd0);
    drain("t1_sb_empty");

    // 2: two ranges, NC=0 then NC=1
    do_reset();
    send(8'h02, 0, 32'd0, 0);
    send(8'h00, 1, ev(3'd1, 3'd0, 7'd0, 7'h00, 1'b1, 1'b1, 1'b0), 0);
    send(8'h00, 1, ev(3'd3, 3'd0, 7'd0, 7'h00, 1'b0, 1'b0, 1'b0), 0);
    send(8'h01, 1, ev(3'd1, 3'd1, 7'd0, 7'h01, 1'b0, 1'b1, 1'b0), 0);
    send(8'h78, 1, ev(3'd2, 3'd1, 7'd0, 7'h78, 1'b0, 1'b0, 1'b0), 0);
    send(8'h00, 1, ev(3'd3, 3'd1, 7'd0, 7'h00, 1'b0, 1'b0, 1'b0), 0);
    send(8'hBB, 1, ev(3'd4, 3'd0, 7'd0, 7'd0,  1'b0, 1'b0, 1'b0), 0);
    drain("t2_sb_empty");

    // 3a: NR=0
    do_reset();
    send(8'h00, 0, 32'd0, 0);
    check_val("t3_nr0_err", {28'd0, err, err_code}, 32'h9);
    check_val("t3_nr0_ready", {31'd0, din_ready}, 32'd0);
    drain("t3a_sb_empty");
    // 3b: NR=9 exceeds RANGES_MAX
    do_reset();
    send(8'h09, 0, 32'd0, 0);
    check_val("t3_nr9_err", {28'd0, err, err_code}, 32'h9);
    drain("t3b_sb_empty");
    // 3c: NC=0x61 (97) exceeds 96
    do_reset();
    send(8'h01, 0, 32'd0, 0);
    send(8'h61, 0, 32'd0, 0);
    check_val("t3_nc_err", {28'd0, err, err_code}, 32'hA);
    drain("t3c_sb_empty");
    // 3d: NC=96 is the largest legal value
    do_reset();
    send(8'h01, 0, 32'd0, 0);
    send(8'h60, 1, ev(3'd1, 3'd0, 7'd0, 7'h60, 1'b0, 1'b0, 1'b0), 0);
    check_val("t3_nc96_ok", {28'd0, err, err_code}, 32'h0);
    drain("t3d_sb_empty");
    // 3e: 8-bit char with 7-bit table
    do_reset();
    send(8'h01, 0, 32'd0, 0);
    send(8'h01, 1, ev(3'd1, 3'd0, 7'd0, 7'h01, 1'b0, 1'b1, 1'b0), 0);
    send(8'h80, 0, 32'd0, 0);
    check_val("t3_char_err", {28'd0, err, err_code}, 32'hB);
    drain("t3e_sb_empty");

    // 4a: SI == NC
    do_reset();
    send(8'h01, 0, 32'd0, 0);
    send(8'h02, 1, ev(3'd1, 3'd0, 7'd0, 7'h02, 1'b0, 1'b0, 1'b0), 0);
    send(8'h61, 1, ev(3'd2, 3'd0, 7'd0, 7'h61, 1'b0, 1'b0, 1'b1), 0);
    send(8'h62, 1, ev(3'd2, 3'd0, 7'd1, 7'h62, 1'b0, 1'b0, 1'b0), 0);
    send(8'h02, 0, 32'd0, 0);
    check_val("t4_si_err", {28'd0, err, err_code}, 32'hC);
    check_val("t4_si_ready", {31'd0, din_ready}, 32'd0);
    drain("t4a_sb_empty");
    // 4b: bad terminator
    do_reset();
    send(8'h01, 0, 32'd0, 0);
    send(8'h00, 1, ev(3'd1, 3'd0, 7'd0, 7'h00, 1'b1, 1'b1, 1'b0), 0);
    send(8'h00, 1, ev(3'd3, 3'd0, 7'd0, 7'h00, 1'b0, 1'b0, 1'b0), 0);
    send(8'hAA, 0, 32'd0, 0);
    check_val("t4_term_err", {28'd0, err, err_code}, 32'hD);
    drain("t4b_sb_empty");

    // 5: stream of test 1 with din_valid low every other cycle
    do_reset();
    stream_t1(1);
    check_val("t5_err", {28'd0, err, err_code}, 32'd0);
    drain("t5_sb_empty");

    // 6: reset after the third char; a byte offered with rstb must not strobe
    do_reset();
    send(8'h01, 0, 32'd0, 0);
    send(8'h03, 1, ev(3'd1, 3'd0, 7'd0, 7'h03, 1'b0, 1'b0, 1'b0), 0);
    send(8'h61, 1, ev(3'd2, 3'd0, 7'd0, 7'h61, 1'b0, 1'b0, 1'b0), 0);
    send(8'h62, 1, ev(3'd2, 3'd0, 7'd1, 7'h62, 1'b0, 1'b0, 1'b1), 0);
    send(8'h63, 1, ev(3'd2, 3'd0, 7'd2, 7'h63, 1'b0, 1'b0, 1'b0), 0);
    rstb = 1'b1;
    din = 8'h01;
    din_valid = 1'b1;
    @(negedge OP_CLK);
    rstb = 1'b0;
    din_valid = 1'b0;
    check_val("t6_rst_outs", {14'd0, conf_en_num_chars, conf_en_chars, conf_en_start_idx,
                              done, err, err_code, conf_range, conf_char_addr}, 32'd0);
    check_val("t6_rst_ready", {31'd0, din_ready}, 32'd1);
    stream_t1(0);
    drain("t6_sb_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
